// File: rtl/fifo_rd_ctrl.sv
// Read-side burst engine: drains len_i words from a 1-cycle-latency fifo into a
// 2-entry skid buffer that feeds a valid/ready stream at up to one word per cycle.
module fifo_rd_ctrl #(
  parameter int WIDTH     = 8,
  parameter int LEN_WIDTH = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [LEN_WIDTH-1:0] remain_o,
  output logic                 err_o,
  output logic                 fifo_rd_en_o,
  input  logic [WIDTH-1:0]     fifo_rdata_i,
  input  logic                 fifo_empty_i,
  input  logic                 fifo_underflow_i,
  output logic                 m_valid_o,
  output logic [WIDTH-1:0]     m_data_o,
  input  logic                 m_ready_i
);

  // state | meaning
  // IDLE  | waiting for start_i
  // RUN   | issuing fifo reads until remain hits 0
  // FLUSH | last read issued; draining in-flight word and buffer
  // DONE  | one-cycle done_o pulse
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] remain_q, remain_d;
  logic                 err_q, err_d;
  logic                 infl_q;
  logic [1:0]           occ_q, occ_d;
  logic [WIDTH-1:0]     buf0_q, buf0_d, buf1_q, buf1_d;
  logic                 pop;
  logic [2:0]           level;

  assign pop       = m_valid_o && m_ready_i;
  // Occupancy the buffer will have once the in-flight word lands and any pop retires.
  assign level     = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
  assign m_valid_o = (occ_q != 2'd0);
  assign m_data_o  = buf0_q;
  assign remain_o  = remain_q;
  assign err_o     = err_q;

  assign fifo_rd_en_o = (state_q == RUN) && !fifo_empty_i &&
                        (remain_q != '0) && (level < 3'd2);

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    err_d    = err_q;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          err_d    = 1'b0;
          remain_d = len_i;
          state_d  = (len_i != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        busy_o = 1'b1;
        if (fifo_rd_en_o) remain_d = remain_q - 1'b1;
        if (remain_q == '0 || (fifo_rd_en_o && remain_q == LEN_WIDTH'(1)))
          state_d = FLUSH;
      end
      FLUSH: begin
        busy_o = 1'b1;
        if (!infl_q && occ_q == 2'd0) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (fifo_underflow_i) err_d = 1'b1;
  end

  // buf0 is the head; a landing word goes to the first free slot.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case ({infl_q, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = fifo_rdata_i;
        else               buf1_d = fifo_rdata_i;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = fifo_rdata_i;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_rdata_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      remain_q <= '0;
      err_q    <= 1'b0;
      infl_q   <= 1'b0;
      occ_q    <= 2'd0;
      buf0_q   <= '0;
      buf1_q   <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      err_q    <= err_d;
      infl_q   <= fifo_rd_en_o;
      occ_q    <= occ_d;
      buf0_q   <= buf0_d;
      buf1_q   <= buf1_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: behavioural fifo, negedge monitor with
// in-order scoreboard, and per-scenario directed checks.
module tb_fifo_rd_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       start_i = 1'b0;
  logic [4:0] len_i = '0;
  logic       busy_o, done_o, err_o, fifo_rd_en_o, m_valid_o;
  logic [4:0] remain_o;
  logic [7:0] fifo_rdata_i;
  logic       fifo_empty_i;
  logic       fifo_underflow_i = 1'b0;
  logic [7:0] m_data_o;
  logic       m_ready_i = 1'b1;

  fifo_rd_ctrl #(.WIDTH(8), .LEN_WIDTH(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .remain_o(remain_o), .err_o(err_o),
    .fifo_rd_en_o(fifo_rd_en_o), .fifo_rdata_i(fifo_rdata_i),
    .fifo_empty_i(fifo_empty_i), .fifo_underflow_i(fifo_underflow_i),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_ready_i(m_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // behavioural fifo with registered empty flag and 1-cycle read latency
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  logic       push_v = 1'b0;
  logic [7:0] push_d = '0;

  initial begin
    fifo_empty_i = 1'b1;
    fifo_rdata_i = '0;
    forever begin
      @(posedge clk_i or negedge rst_i);
      if (!rst_i) begin
        fq.delete();
        fifo_empty_i <= 1'b1;
        fifo_rdata_i <= '0;
      end else begin
        if (fifo_rd_en_o && fq.size() > 0) fifo_rdata_i <= fq.pop_front();
        if (push_v) fq.push_back(push_d);
        fifo_empty_i <= (fq.size() == 0);
      end
    end
  end

  // monitor: protocol and ordering checks sampled mid-cycle
  int ncyc = 0, cnt = 0, rd_cnt = 0, xfer_cnt = 0, done_cnt = 0;
  int first_v = -1, first_x = -1, last_x = -1, done_cyc = -1;
  logic hold = 1'b0;
  logic [7:0] hold_data = '0;

  initial begin
    forever begin
      logic pop;
      @(negedge clk_i);
      ncyc++;
      if (!rst_i) begin
        cnt  = 0;
        hold = 1'b0;
        continue;
      end
      pop = m_valid_o && m_ready_i;
      if (fifo_rd_en_o) begin
        rd_cnt++;
        chk("rd_when_empty", 32'(fifo_empty_i), 0);
        chk("rd_occ_limit", 32'((cnt - int'(pop)) < 2), 1);
      end
      if (hold) begin
        chk("hold_valid", 32'(m_valid_o), 1);
        chk("hold_data", 32'(m_data_o), 32'(hold_data));
      end
      if (m_valid_o && first_v < 0) first_v = ncyc;
      if (pop) begin
        if (exp_q.size() == 0) chk("word_expected", exp_q.size(), 1);
        else chk("word_order", 32'(m_data_o), 32'(exp_q.pop_front()));
        xfer_cnt++;
        if (first_x < 0) first_x = ncyc;
        last_x = ncyc;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = ncyc;
      end
      cnt       = cnt + int'(fifo_rd_en_o) - int'(pop);
      hold      = m_valid_o && !m_ready_i;
      hold_data = m_data_o;
    end
  end

  task automatic clear_stats();
    rd_cnt = 0; xfer_cnt = 0; done_cnt = 0;
    first_v = -1; first_x = -1; last_x = -1; done_cyc = -1;
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      push_v = 1'b1;
      push_d = base + 8'(i);
      exp_q.push_back(base + 8'(i));
    end
    @(posedge clk_i); #1;
    push_v = 1'b0;
    @(posedge clk_i); #1;
  endtask

  // returns the negedge index of the cycle in which start_i is high
  task automatic start_burst(input logic [4:0] len, output int st_cyc);
    @(posedge clk_i); #1;
    start_i = 1'b1;
    len_i   = len;
    st_cyc  = ncyc + 1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      @(posedge clk_i); #1;
    end
    if (done_cnt == 0) chk({tag, "_done_timeout"}, done_cnt, 1);
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  initial begin
    int st;
    int pushed;

    // reset state
    #1;
    chk("rst_busy",   32'(busy_o), 0);
    chk("rst_done",   32'(done_o), 0);
    chk("rst_err",    32'(err_o), 0);
    chk("rst_rd_en",  32'(fifo_rd_en_o), 0);
    chk("rst_valid",  32'(m_valid_o), 0);
    chk("rst_remain", 32'(remain_o), 0);
    chk("rst_data",   32'(m_data_o), 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;

    // 1: full 16-word burst at full rate
    fill(16, 8'h10);
    clear_stats();
    start_burst(5'd16, st);
    chk("t1_busy", 32'(busy_o), 1);
    wait_done("t1", 60);
    chk("t1_xfers", xfer_cnt, 16);
    chk("t1_rate", last_x - first_x, 15);
    chk("t1_first_lat", 32'((first_v - st) <= 3), 1);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_remain", 32'(remain_o), 0);
    chk("t1_err", 32'(err_o), 0);
    chk("t1_left", exp_q.size(), 0);

    // 2: ready toggling
    fill(8, 8'h40);
    clear_stats();
    start_burst(5'd8, st);
    for (int i = 0; i < 80 && done_cnt == 0; i++) begin
      @(posedge clk_i); #1;
      m_ready_i = ~m_ready_i;
    end
    m_ready_i = 1'b1;
    wait_done("t2", 10);
    chk("t2_xfers", xfer_cnt, 8);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_left", exp_q.size(), 0);

    // 3: starved fifo, one word every 5 cycles
    clear_stats();
    start_burst(5'd4, st);
    pushed = 0;
    for (int i = 0; i < 100 && done_cnt == 0; i++) begin
      @(posedge clk_i); #1;
      push_v = (i % 5 == 0) && (pushed < 4);
      if (push_v) begin
        push_d = 8'hA0 + 8'(pushed);
        exp_q.push_back(8'hA0 + 8'(pushed));
        pushed++;
      end
    end
    push_v = 1'b0;
    wait_done("t3", 10);
    chk("t3_xfers", xfer_cnt, 4);
    chk("t3_reads", rd_cnt, 4);
    chk("t3_done_cnt", done_cnt, 1);

    // 4: zero-length burst
    clear_stats();
    start_burst(5'd0, st);
    wait_done("t4", 10);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_done_lat", 32'((done_cyc - st) >= 1 && (done_cyc - st) <= 2), 1);
    chk("t4_reads", rd_cnt, 0);

    // 5: underflow mid-burst is sticky until the next start
    fill(8, 8'h60);
    clear_stats();
    start_burst(5'd8, st);
    @(posedge clk_i); #1;
    fifo_underflow_i = 1'b1;
    @(posedge clk_i); #1;
    fifo_underflow_i = 1'b0;
    chk("t5_err_set", 32'(err_o), 1);
    wait_done("t5", 40);
    chk("t5_err_sticky", 32'(err_o), 1);
    chk("t5_xfers", xfer_cnt, 8);
    clear_stats();
    start_burst(5'd0, st);
    chk("t5_err_clr", 32'(err_o), 0);
    wait_done("t5b", 10);

    // 6: stalled consumer, ignored start, then reset with a full buffer
    fill(8, 8'h80);
    clear_stats();
    m_ready_i = 1'b0;
    start_burst(5'd8, st);
    repeat (5) @(posedge clk_i);
    #1;
    chk("t6_valid", 32'(m_valid_o), 1);
    chk("t6_remain", 32'(remain_o), 6);
    @(posedge clk_i); #1;
    start_i = 1'b1;
    len_i   = 5'd3;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("t6_ign_remain", 32'(remain_o), 6);
    chk("t6_ign_busy", 32'(busy_o), 1);
    @(negedge clk_i); #2;
    rst_i = 1'b0;
    #1;
    chk("t6_rst_busy",   32'(busy_o), 0);
    chk("t6_rst_valid",  32'(m_valid_o), 0);
    chk("t6_rst_data",   32'(m_data_o), 0);
    chk("t6_rst_remain", 32'(remain_o), 0);
    chk("t6_rst_rd_en",  32'(fifo_rd_en_o), 0);
    chk("t6_rst_done",   32'(done_o), 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    m_ready_i = 1'b1;
    exp_q.delete();
    chk("t6_no_done", done_cnt, 0);
    fill(4, 8'hC0);
    clear_stats();
    start_burst(5'd4, st);
    wait_done("t6", 30);
    chk("t6_xfers", xfer_cnt, 4);
    chk("t6_left", exp_q.size(), 0);
    chk("t6_done_cnt", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout want completion");
    $fatal(1);
  end

endmodule
